inst_fetch_queue: RTL and testbench

Parametrised instruction fetch unit with a decoupling instruction queue, sitting between the instruction cache, the PC predictor and the decoder. It keeps a single request outstanding to the cache and buffers returned instructions in a DEPTH-entry FIFO. The decoder drains the FIFO one entry per issue. A ROB redirect flushes the queue and restarts fetch at the corrected PC.

---
 rtl/inst_fetch_queue.sv | 126 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch unit with a DEPTH-entry decoupling queue. Keeps one
//   request outstanding to the instruction cache, buffers returned
//   {address, instruction} pairs and presents the queue head to the decoder.
//   A ROB redirect empties the queue and restarts fetch at the new PC.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global ready; low freezes all state
//   rob_clear_up/next_pc    redirect pulse and target
//   pc, start_fetch         registered fetch address and request level
//   fetch_ready, inst,      cache response strobe and payload
//   inst_addr
//   pc_predictor_next_pc    predicted successor of the returning instruction
//   start_decode,           queue head valid and contents (0 when empty)
//   inst_out, inst_addr_out
//   issue_signal            decoder consumed the head
//   overflow_err            sticky: response arrived while full with no pop
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            rob_clear_up,
  input  logic [XLEN-1:0] rob_next_pc,
  output logic [XLEN-1:0] pc,
  output logic            start_fetch,
  input  logic            fetch_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] pc_predictor_next_pc,
  output logic            start_decode,
  output logic [XLEN-1:0] inst_addr_out,
  output logic [XLEN-1:0] inst_out,
  input  logic            issue_signal,
  output logic            overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] r_addr_q [DEPTH];
  logic [XLEN-1:0] r_inst_q [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc;
  logic            r_start_fetch;
  logic            r_overflow;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [CW-1:0]   w_count_next;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = issue_signal && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign w_push  = fetch_ready && (!w_full || w_pop);
  assign w_drop  = fetch_ready && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_pc          <= RESET_PC;
      r_start_fetch <= 1'b1;
      r_overflow    <= 1'b0;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        // The cache is flushed by the same pulse, so any response this cycle is stale.
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_pc          <= rob_next_pc;
        r_start_fetch <= 1'b1;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + AW'(1);
          r_pc   <= pc_predictor_next_pc;
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        r_count       <= w_count_next;
        r_start_fetch <= (w_count_next < FULL_CNT);
      end
    end
  end

  // Entry storage needs no reset: contents are only visible while count > 0.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !rob_clear_up && w_push) begin
      r_addr_q[r_tail] <= inst_addr;
      r_inst_q[r_tail] <= inst;
    end
  end

  assign pc            = r_pc;
  assign start_fetch   = r_start_fetch;
  assign overflow_err  = r_overflow;
  assign start_decode  = !w_empty;
  assign inst_addr_out = w_empty ? '0 : r_addr_q[r_head];
  assign inst_out      = w_empty ? '0 : r_inst_q[r_head];

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear_up;
  logic [31:0] rob_next_pc;
  logic [31:0] pc;
  logic        start_fetch;
  logic        fetch_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic [31:0] pc_predictor_next_pc;
  logic        start_decode;
  logic [31:0] inst_addr_out;
  logic [31:0] inst_out;
  logic        issue_signal;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  inst_fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .rob_clear_up         (rob_clear_up),
    .rob_next_pc          (rob_next_pc),
    .pc                   (pc),
    .start_fetch          (start_fetch),
    .fetch_ready          (fetch_ready),
    .inst                 (inst),
    .inst_addr            (inst_addr),
    .pc_predictor_next_pc (pc_predictor_next_pc),
    .start_decode         (start_decode),
    .inst_addr_out        (inst_addr_out),
    .inst_out             (inst_out),
    .issue_signal         (issue_signal),
    .overflow_err         (overflow_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    fetch_ready  = 1'b0;
    issue_signal = 1'b0;
    rob_clear_up = 1'b0;
  endtask

  // One cycle with a cache response (and optional pop); instruction = 0x1000 + addr.
  task automatic resp(input logic [31:0] a, input logic [31:0] pred, input logic pop);
    fetch_ready          = 1'b1;
    inst_addr            = a;
    inst                 = 32'h1000 + a;
    pc_predictor_next_pc = pred;
    issue_signal         = pop;
    step();
    idle();
  endtask

  task automatic pop_one();
    issue_signal = 1'b1;
    step();
    idle();
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_next_pc = '0;
    inst = '0; inst_addr = '0; pc_predictor_next_pc = '0;
    idle();
    step(); step();
    rst_in = 1'b0;

    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_start_fetch", {31'b0, start_fetch}, 32'd1);
    check_eq("rst_start_decode", {31'b0, start_decode}, 32'd0);
    check_eq("rst_inst_out", inst_out, 32'h0);
    check_eq("rst_inst_addr_out", inst_addr_out, 32'h0);
    check_eq("rst_overflow", {31'b0, overflow_err}, 32'd0);

    // single fetch
    fetch_ready = 1'b1; inst = 32'h00500093; inst_addr = 32'h0; pc_predictor_next_pc = 32'h4;
    step(); idle();
    check_eq("single_start_decode", {31'b0, start_decode}, 32'd1);
    check_eq("single_inst_out", inst_out, 32'h00500093);
    check_eq("single_addr_out", inst_addr_out, 32'h0);
    check_eq("single_pc", pc, 32'h4);
    check_eq("single_start_fetch", {31'b0, start_fetch}, 32'd1);

    // fill to DEPTH
    resp(32'h4, 32'h8, 1'b0);
    check_eq("fill2_start_fetch", {31'b0, start_fetch}, 32'd1);
    resp(32'h8, 32'hC, 1'b0);
    check_eq("fill3_start_fetch", {31'b0, start_fetch}, 32'd1);
    resp(32'hC, 32'h10, 1'b0);
    check_eq("full_start_fetch", {31'b0, start_fetch}, 32'd0);
    check_eq("full_pc", pc, 32'h10);
    check_eq("full_head", inst_addr_out, 32'h0);

    // overflow: dropped response
    resp(32'h10, 32'h14, 1'b0);
    check_eq("ovf_flag", {31'b0, overflow_err}, 32'd1);
    check_eq("ovf_pc_held", pc, 32'h10);
    check_eq("ovf_head", inst_addr_out, 32'h0);
    check_eq("ovf_start_fetch", {31'b0, start_fetch}, 32'd0);

    // full + simultaneous push/pop
    resp(32'h10, 32'h14, 1'b1);
    check_eq("pp_head", inst_addr_out, 32'h4);
    check_eq("pp_head_inst", inst_out, 32'h1004);
    check_eq("pp_start_fetch", {31'b0, start_fetch}, 32'd0);
    check_eq("pp_pc", pc, 32'h14);

    // drain
    pop_one();
    check_eq("drain1_head", inst_addr_out, 32'h8);
    check_eq("drain1_start_fetch", {31'b0, start_fetch}, 32'd1);
    pop_one();
    check_eq("drain2_head", inst_addr_out, 32'hC);
    pop_one();
    check_eq("drain3_head", inst_addr_out, 32'h10);
    check_eq("drain3_inst", inst_out, 32'h1010);
    pop_one();
    check_eq("drain_empty", {31'b0, start_decode}, 32'd0);
    check_eq("drain_empty_inst", inst_out, 32'h0);
    check_eq("drain_empty_addr", inst_addr_out, 32'h0);
    pop_one();
    check_eq("pop_empty_ignored", {31'b0, start_decode}, 32'd0);

    // interleaved push/pop across pointer wrap
    resp(32'h200, 32'h204, 1'b0);
    check_eq("wrap_first", inst_addr_out, 32'h200);
    for (int i = 1; i < 10; i++) begin
      resp(32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i), 1'b1);
      check_eq($sformatf("wrap_head_%0d", i), inst_addr_out, 32'h200 + 32'(4 * i));
      check_eq($sformatf("wrap_inst_%0d", i), inst_out, 32'h1200 + 32'(4 * i));
    end
    check_eq("wrap_pc", pc, 32'h228);
    pop_one();
    check_eq("wrap_empty", {31'b0, start_decode}, 32'd0);

    // flush mid-operation with a colliding response and pop
    resp(32'h300, 32'h304, 1'b0);
    resp(32'h304, 32'h308, 1'b0);
    resp(32'h308, 32'h30C, 1'b0);
    check_eq("pre_flush_head", inst_addr_out, 32'h300);
    rob_clear_up = 1'b1; rob_next_pc = 32'h100;
    resp(32'h30C, 32'h310, 1'b1);
    check_eq("flush_start_decode", {31'b0, start_decode}, 32'd0);
    check_eq("flush_pc", pc, 32'h100);
    check_eq("flush_start_fetch", {31'b0, start_fetch}, 32'd1);
    resp(32'h100, 32'h104, 1'b0);
    check_eq("post_flush_head", inst_addr_out, 32'h100);
    check_eq("post_flush_pc", pc, 32'h104);
    resp(32'h104, 32'h108, 1'b0);

    // rdy_in low freezes everything
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_ready = 1'b1; inst_addr = 32'h108; inst = 32'h1108;
      pc_predictor_next_pc = 32'h10C; issue_signal = 1'b1;
      step();
      check_eq($sformatf("frz_head_%0d", i), inst_addr_out, 32'h100);
      check_eq($sformatf("frz_pc_%0d", i), pc, 32'h108);
    end
    idle();
    rdy_in = 1'b1;
    pop_one();
    check_eq("resume_head", inst_addr_out, 32'h104);
    pop_one();
    check_eq("resume_empty", {31'b0, start_decode}, 32'd0);
    check_eq("ovf_sticky", {31'b0, overflow_err}, 32'd1);

    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_eq("rst2_overflow", {31'b0, overflow_err}, 32'd0);
    check_eq("rst2_pc", pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
